axis_frame_packetizer: RTL

Parametrised successor to the basic AXI4-Stream packetizer. Slices a continuous sample stream into frames of runtime-programmable length. Features: programmable packet count (finite or endless), programmable inter-packet gap, optional header word carrying a wrapping sequence number, and graceful start/stop control. Sits between an ADC/DSP stream source and a DMA writer or UDP framer, with a registered output stage.

---
 rtl/axis_pkt_pkg.sv | 16 +
 rtl/axis_skid_buffer.sv | 68 ++++++
 rtl/axis_frame_packetizer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the AXI4-Stream frame packetizer and its output stage.
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        GAP
    } pkt_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    localparam string STR_TRUE  = "TRUE";
    localparam string STR_FALSE = "FALSE";

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer: registered outputs, registered upstream ready,
// one cycle of latency and full throughput.
module axis_skid_buffer
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 33
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    // entry 0 drives the output port, entry 1 catches a word while the output stalls
    logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] valid_q;
    logic [SKID_DEPTH-1:0] valid_d;
    logic                  ready_q;
    logic                  s_fire;
    logic                  out_free;

    assign s_fire   = s_valid && ready_q;
    assign out_free = m_ready || !valid_q[0];

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (out_free) begin
            if (valid_q[1]) begin
                data_d[0]  = data_q[1];
                valid_d[0] = 1'b1;
                valid_d[1] = 1'b0;
            end else begin
                valid_d[0] = s_fire;
                if (s_fire) begin
                    data_d[0] = s_data;
                end
            end
        end else if (s_fire) begin
            data_d[1]  = s_data;
            valid_d[1] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            ready_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= !valid_d[1];
        end
    end

    assign s_ready = ready_q;
    assign m_data  = data_q[0];
    assign m_valid = valid_q[0];

endmodule

// File: rtl/axis_frame_packetizer.sv
// Slices a sample stream into frames of programmable length and count, with an optional
// sequence-number header, an inter-packet gap and graceful start/stop.
module axis_frame_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    CNTR_WIDTH       = 32,
    parameter string HEADER_ENABLE    = STR_FALSE,
    parameter string ALWAYS_READY     = STR_FALSE
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_packets,
    input  logic [CNTR_WIDTH-1:0]       cfg_gap,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic [CNTR_WIDTH-1:0]       sts_packets,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    localparam bit                    HDR_EN      = (HEADER_ENABLE == STR_TRUE);
    localparam bit                    ALW_RDY     = (ALWAYS_READY == STR_TRUE);
    localparam pkt_state_t            FIRST_STATE = HDR_EN ? HEADER : DATA;
    localparam logic [CNTR_WIDTH-1:0] ONE         = CNTR_WIDTH'(1);

    pkt_state_t                  state_q, state_d;
    logic [CNTR_WIDTH-1:0]       len_q, packets_q, gap_q;
    logic [CNTR_WIDTH-1:0]       word_cntr_q, gap_cntr_q, pkt_cntr_q, seq_q;
    logic                        stop_req_q, done_q, rdy_en_q;

    logic                        skid_ready;
    logic                        push_valid, push_last;
    logic [AXIS_TDATA_WIDTH-1:0] push_data;
    logic [AXIS_TDATA_WIDTH:0]   skid_out;
    logic                        start_ok, stop_now, in_fire, hdr_fire;
    logic                        last_word, pkt_end, final_pkt, gap_end;

    assign start_ok  = cfg_start && (cfg_length != '0);
    assign stop_now  = stop_req_q || cfg_stop;
    assign in_fire   = (state_q == DATA) && s_axis_tvalid && skid_ready;
    assign hdr_fire  = (state_q == HEADER) && skid_ready;
    assign last_word = (word_cntr_q == len_q - ONE);
    assign pkt_end   = in_fire && last_word;
    assign final_pkt = stop_now || ((packets_q != '0) && (pkt_cntr_q + ONE == packets_q));
    assign gap_end   = (gap_cntr_q == gap_q - ONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = FIRST_STATE;
            HEADER:  if (hdr_fire) state_d = DATA;
            DATA: begin
                if (pkt_end) begin
                    if (final_pkt)          state_d = IDLE;
                    else if (gap_q != '0)   state_d = GAP;
                    else                    state_d = FIRST_STATE;
                end
            end
            GAP: begin
                if (stop_now)     state_d = IDLE;
                else if (gap_end) state_d = FIRST_STATE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outside DATA the input is either held off or, with ALWAYS_READY, accepted and dropped
    always_comb begin
        push_valid    = 1'b0;
        push_data     = '0;
        push_last     = 1'b0;
        s_axis_tready = ALW_RDY && rdy_en_q;
        unique case (state_q)
            HEADER: begin
                push_valid = 1'b1;
                push_data  = AXIS_TDATA_WIDTH'(seq_q);
            end
            DATA: begin
                push_valid    = s_axis_tvalid;
                push_data     = s_axis_tdata;
                push_last     = last_word;
                s_axis_tready = ALW_RDY ? rdy_en_q : skid_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            packets_q   <= '0;
            gap_q       <= '0;
            word_cntr_q <= '0;
            gap_cntr_q  <= '0;
            pkt_cntr_q  <= '0;
            seq_q       <= '0;
            stop_req_q  <= 1'b0;
            done_q      <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            done_q     <= (state_q != IDLE) && (state_d == IDLE);
            stop_req_q <= (state_d != IDLE) && (stop_req_q || cfg_stop);
            if ((state_q == IDLE) && start_ok) begin
                len_q      <= cfg_length;
                packets_q  <= cfg_packets;
                gap_q      <= cfg_gap;
                pkt_cntr_q <= '0;
                seq_q      <= '0;
            end
            if (in_fire) begin
                word_cntr_q <= last_word ? '0 : word_cntr_q + ONE;
            end
            if (pkt_end) begin
                pkt_cntr_q <= pkt_cntr_q + ONE;
                seq_q      <= seq_q + ONE;
            end
            gap_cntr_q <= (state_q == GAP) ? gap_cntr_q + ONE : '0;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH + 1)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  ({push_last, push_data}),
        .s_valid (push_valid),
        .s_ready (skid_ready),
        .m_data  (skid_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = skid_out[AXIS_TDATA_WIDTH-1:0];
    assign m_axis_tlast = skid_out[AXIS_TDATA_WIDTH];
    assign sts_busy     = (state_q != IDLE);
    assign sts_done     = done_q;
    assign sts_packets  = pkt_cntr_q;

endmodule
